// File: rtl/lcg_vec_gen.sv
// Wide pseudo-random vector generator: a 32-bit LCG fills one 32-bit word of
// the output vector per clock, and each finished vector is offered on a valid/ready handshake.
module lcg_vec_gen #(
  parameter int unsigned OUT_W        = 254,
  parameter logic [31:0] SEED_DEFAULT = 32'hFF01CF99,
  parameter logic [31:0] LCG_MUL      = 32'h41C64E6D,
  parameter logic [31:0] LCG_INC      = 32'h00003039,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  output logic             vec_valid,
  input  logic             vec_ready,
  output logic [OUT_W-1:0] vec_data,
  output logic [CNT_W-1:0] vec_idx,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NW    = (OUT_W + 31) / 32;
  localparam int unsigned EXT_W = NW * 32;
  localparam int unsigned PTR_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [PTR_W-1:0] LAST_WORD = PTR_W'(NW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             r_state;
  logic [31:0]        r_lcg;
  logic [OUT_W-1:0]   r_data;
  logic [CNT_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_w;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  logic [31:0]        w_lcg_next;
  logic [PTR_W+4:0]   w_shamt;
  logic [EXT_W-1:0]   w_word_ext;
  logic [EXT_W-1:0]   w_mask_ext;
  logic [OUT_W-1:0]   w_data_next;
  logic [CNT_W-1:0]   w_idx_inc;
  logic               w_last_vec;

  assign w_lcg_next = r_lcg * LCG_MUL + LCG_INC;

  // Place s_next at word r_w; bits shifted past OUT_W fall off, trimming the last word.
  assign w_shamt     = {r_w, 5'b00000};
  assign w_word_ext  = EXT_W'(w_lcg_next) << w_shamt;
  assign w_mask_ext  = EXT_W'(32'hFFFF_FFFF) << w_shamt;
  assign w_data_next = (r_data & ~OUT_W'(w_mask_ext)) | OUT_W'(w_word_ext);

  assign w_idx_inc  = r_idx + CNT_W'(1);
  assign w_last_vec = (r_cnt != '0) && (w_idx_inc == r_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lcg   <= SEED_DEFAULT;
      r_data  <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_w     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Seed lands first so a same-cycle start generates from the new seed.
          if (seed_load) begin
            r_lcg <= seed;
          end
          if (start) begin
            r_state <= S_FILL;
            r_cnt   <= num_vec;
            r_idx   <= '0;
            r_w     <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        S_FILL: begin
          r_lcg  <= w_lcg_next;
          r_data <= w_data_next;
          if (r_w == LAST_WORD) begin
            r_w     <= '0;
            r_state <= S_PRESENT;
            r_valid <= 1'b1;
          end else begin
            r_w <= r_w + PTR_W'(1);
          end
        end
        S_PRESENT: begin
          if (vec_ready) begin
            r_valid <= 1'b0;
            if (w_last_vec) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= w_idx_inc;
              r_w     <= '0;
              r_state <= S_FILL;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_valid = r_valid;
  assign vec_data  = r_data;
  assign vec_idx   = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_lcg_vec_gen.sv
// Scoreboard bench for lcg_vec_gen: stimulus pushes model vectors into a queue,
// a negedge monitor compares every presented vector against the queue head.
module tb_lcg_vec_gen;

  localparam int unsigned OUT_W = 254;
  localparam int unsigned NW    = (OUT_W + 31) / 32;
  localparam int unsigned CNT_W = 32;
  localparam logic [31:0] SEED_DEFAULT = 32'hFF01CF99;
  localparam logic [31:0] LCG_MUL      = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC      = 32'h00003039;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             seed_load = 1'b0;
  logic [31:0]      seed = '0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             vec_valid;
  logic             vec_ready = 1'b0;
  logic [OUT_W-1:0] vec_data;
  logic [CNT_W-1:0] vec_idx;
  logic             busy;
  logic             done;

  lcg_vec_gen #(
    .OUT_W(OUT_W), .SEED_DEFAULT(SEED_DEFAULT), .LCG_MUL(LCG_MUL),
    .LCG_INC(LCG_INC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .start(start),
    .num_vec(num_vec), .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_data(vec_data), .vec_idx(vec_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] idx;
  } exp_t;

  exp_t        q[$];
  int unsigned hs_q[$];
  int unsigned hs_cnt = 0;
  logic [31:0] m_lcg = SEED_DEFAULT;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: a vector is NW successive LCG outputs concatenated, word 0 lowest, truncated to OUT_W.
  task automatic push_vecs(input int n, input logic [CNT_W-1:0] idx0);
    logic [NW*32-1:0] acc;
    exp_t e;
    for (int v = 0; v < n; v++) begin
      for (int k = 0; k < NW; k++) begin
        m_lcg = m_lcg * LCG_MUL + LCG_INC;
        acc[k*32 +: 32] = m_lcg;
      end
      e.data = acc[OUT_W-1:0];
      e.idx  = idx0 + CNT_W'(v);
      q.push_back(e);
    end
  endtask

  // Monitor: compare every presented vector (stalled ones too) with the queue head.
  always @(negedge clk) begin
    if (!rst && vec_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_vector: got idx %0d expected no vector", vec_idx);
      end else begin
        chk("vec_data", 256'(vec_data), 256'(q[0].data));
        chk("vec_idx", 256'(vec_idx), 256'(q[0].idx));
        if (vec_ready === 1'b1) begin
          void'(q.pop_front());
          hs_q.push_back(cyc);
          hs_cnt++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vec_ready = 1'b0;
    tick();
    chk("rst_valid", 256'(vec_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_idx", 256'(vec_idx), 256'(0));
    chk("rst_data", 256'(vec_data), 256'(0));
    tick();
    rst = 1'b0;
    m_lcg = SEED_DEFAULT;
    q.delete();
  endtask

  task automatic start_run(input logic [CNT_W-1:0] n, input bit do_seed, input logic [31:0] sd);
    seed_load = do_seed;
    seed      = sd;
    num_vec   = n;
    start     = 1'b1;
    if (do_seed) m_lcg = sd;
    if (n != 0) push_vecs(int'(n), '0);
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_rdy);
    int i;
    for (i = 0; i < budget && done !== 1'b1; i++) begin
      if (rand_rdy) vec_ready = ($urandom_range(0, 3) != 0);
      else vec_ready = 1'b1;
      tick();
    end
    vec_ready = 1'b0;
    chk("run_done", 256'(done), 256'(1));
    chk("run_not_busy", 256'(busy), 256'(0));
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && vec_valid !== 1'b1; i++) tick();
    chk("wait_valid", 256'(vec_valid), 256'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int unsigned base;
    int unsigned hs0;

    do_reset();

    // Default seed, 3 vectors, ready held high: latency and spacing.
    base = hs_q.size();
    vec_ready = 1'b1;
    c0 = cyc;
    start_run(3, 1'b0, '0);
    wait_done(100, 1'b0);
    chk("hs_count_3", 256'(hs_q.size() - base), 256'(3));
    if (hs_q.size() - base == 3) begin
      chk("first_latency", 256'(hs_q[base]), 256'(c0 + 1 + NW));
      chk("spacing_01", 256'(hs_q[base+1] - hs_q[base]), 256'(NW + 1));
      chk("spacing_12", 256'(hs_q[base+2] - hs_q[base+1]), 256'(NW + 1));
    end

    // Seed 0 with same-cycle start: known constants in the low words.
    start_run(1, 1'b1, 32'h0);
    wait_done(100, 1'b1);
    chk("seed0_word0", 256'(vec_data[31:0]), 256'(32'h0000_3039));
    chk("seed0_byte4", 256'(vec_data[39:32]), 256'(8'h7E));
    chk("done_holds_idx", 256'(vec_idx), 256'(0));

    // Backpressure: 5 stalled cycles, accept on first ready.
    start_run(2, 1'b0, '0);
    vec_ready = 1'b0;
    wait_valid(50);
    for (int i = 0; i < 5; i++) tick();
    hs0 = hs_cnt;
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    chk("bp_accept", 256'(hs_cnt), 256'(hs0 + 1));
    chk("bp_valid_falls", 256'(vec_valid), 256'(0));
    wait_done(100, 1'b0);

    // Perturbation: start/seed_load in FILL and seed_load in PRESENT are ignored.
    start_run(2, 1'b0, '0);
    tick();
    start = 1'b1; seed_load = 1'b1; seed = $urandom; num_vec = 5;
    tick();
    start = 1'b0; seed_load = 1'b0;
    wait_valid(50);
    seed_load = 1'b1; seed = $urandom;
    tick();
    seed_load = 1'b0;
    wait_done(100, 1'b1);
    chk("perturb_idx", 256'(vec_idx), 256'(1));

    // Reset mid-FILL at word pointer 3, then reproduce from SEED_DEFAULT.
    start_run(0, 1'b0, '0);
    tick(); tick(); tick();
    chk("midfill_busy", 256'(busy), 256'(1));
    chk("midfill_valid", 256'(vec_valid), 256'(0));
    do_reset();
    start_run(2, 1'b0, '0);
    wait_done(100, 1'b1);

    // Unbounded: 1000 vectors with indices 0..999, never done.
    start_run(0, 1'b0, '0);
    push_vecs(1001, '0);
    base = hs_cnt;
    vec_ready = 1'b1;
    for (int i = 0; i < 1001 * (NW + 1) + 50 && (hs_cnt - base) < 1000; i++) begin
      tick();
      if (done === 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL unbounded_done: got 1 expected 0");
      end
    end
    vec_ready = 1'b0;
    chk("unbounded_count", 256'(hs_cnt - base), 256'(1000));
    for (int i = 0; i < NW + 3; i++) tick();
    chk("unbounded_not_done", 256'(done), 256'(0));
    chk("unbounded_busy", 256'(busy), 256'(1));
    do_reset();

    // Restart from DONE continues the LCG stream.
    start_run(2, 1'b0, '0);
    wait_done(100, 1'b1);
    start_run(2, 1'b0, '0);
    wait_done(100, 1'b1);

    // Random seeds and counts with random ready.
    for (int r = 0; r < 4; r++) begin
      start_run(CNT_W'($urandom_range(1, 4)), 1'b1, $urandom);
      wait_done(200, 1'b1);
    end

    tick();
    chk("queue_empty", 256'(q.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcg_vec_gen.md
Name: lcg_vec_gen

Overview:
- Synthesizable, parametrised successor to the fuzz harness's behavioural LCG stimulus loop. Generates OUT_W-bit pseudo-random vectors from a 32-bit LCG, one 32-bit word per clock.
- Presents each vector on a valid/ready handshake and stops after a programmable vector count.
- Sits between the harness control logic and the DUT input bus, so stimulus can be regenerated bit-exactly in any simulator or on FPGA.

Parameters:
- OUT_W, 254: output vector width; NW = ceil(OUT_W/32) words per vector (derived, not overridable).
- SEED_DEFAULT, 32'hFF01CF99: LCG state after reset.
- LCG_MUL, 32'h41C64E6D: LCG multiplier.
- LCG_INC, 32'h00003039: LCG increment.
- CNT_W, 32: width of vector count and index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  load seed into LCG state; honoured only in IDLE or DONE.
- seed  in  32  seed value.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- num_vec  in  CNT_W  vectors per run, sampled with start; 0 = unbounded.
- vec_valid  out  1  vec_data holds a complete vector.
- vec_ready  in  1  consumer accepts vector.
- vec_data  out  OUT_W  generated vector.
- vec_idx  out  CNT_W  index of the vector currently presented (0-based).
- busy  out  1  high in FILL or PRESENT.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=1 at a clk edge, any state, including mid-run): state=IDLE, LCG state=SEED_DEFAULT, vec_data=0, vec_valid=0, vec_idx=0, busy=0, done=0, word pointer=0, latched count=0.
- LCG step: s_next = (s*LCG_MUL + LCG_INC) mod 2^32. Exactly one step per FILL cycle and no steps in any other state.
- States:
  - IDLE: start=1 -> FILL; latch num_vec, vec_idx=0, w=0.
  - FILL: each cycle, step the LCG and write s_next into word w of vec_data (bits 32w+31:32w), then w++. On the word w=NW-1, write only the low OUT_W-32*(NW-1) bits of s_next and go to PRESENT.
  - PRESENT: vec_valid=1. When vec_ready=1:
    - if latched count != 0 and vec_idx+1 == count -> DONE (vec_idx holds its value);
    - else vec_idx++, w=0 -> FILL.
  - DONE: done=1, vec_data and vec_idx hold their values. start=1 -> FILL with vec_idx=0, continuing from the current LCG state.
- Timing:
  - vec_valid rises NW edges after the edge that samples start or the previous handshake.
  - Throughput is one vector per NW+1 cycles when vec_ready is tied high.
- Stability: vec_data and vec_idx hold while vec_valid=1 and vec_ready=0. vec_valid falls on the edge after the handshake. vec_ready outside PRESENT is ignored.
- Word ordering: word 0 is the first LCG output after start, matching the harness loop that fills in_flat[31:0] first.
- start and seed_load in the same IDLE/DONE cycle: the seed loads first, so word 0 = LCG(seed).
- start or seed_load while busy: ignored, no effect on state, LCG or count.
- vec_idx wraps mod 2^CNT_W in unbounded mode; no error is flagged.
- Arithmetic is unsigned 32x32 with the product truncated to 32 bits. The multiply may be pipelined internally only if every timing rule above still holds.

Test Plan:
- OUT_W=40, seed_load with seed=0, start with num_vec=1, vec_ready=1 -> vec_valid rises 2 edges after start; vec_data=40'h7E00003039; one handshake, then done=1, busy=0.
- Default params, no seed_load, start with num_vec=3, vec_ready=1 -> exactly 3 handshakes with vec_idx 0,1,2, each 9 cycles apart. Word 0 of vector 0 = SEED_DEFAULT*LCG_MUL+LCG_INC mod 2^32. Bits 253:224 = low 30 bits of the 8th step. Result matches a software LCG model bit-exactly.
- Backpressure: vec_ready low for 5 cycles in PRESENT -> vec_data and vec_idx unchanged for all 5 cycles, no LCG steps; the vector is accepted on the first ready cycle.
- start and seed_load pulsed during FILL, and seed_load during PRESENT -> no effect; the output sequence is identical to an unperturbed run.
- rst asserted mid-FILL (w=3) -> next cycle all outputs 0, state IDLE. A new start with no seed_load reproduces the post-reset sequence from SEED_DEFAULT.
- num_vec=0 with vec_ready=1 for 1000 vectors -> never done; vec_idx increments 0..999; restart from DONE (after a num_vec=2 run) continues the LCG stream without repeating vectors.
